sdp_ram: RTL and testbench
==========================

SDP_RAM -- requirements
Module: sdp_ram

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, at least 1.
REQ-002 Parameter ADDR, default 4: address width; depth is 2**ADDR words.
REQ-003 Parameter LANES, default 1: number of write-enable lanes; WIDTH SHALL be divisible by LANES, and each lane is WIDTH/LANES bits.
REQ-004 Parameter OUT_REG, default 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
REQ-005 Parameter INIT_VAL, default 0 (WIDTH bits): value written to every word during initialisation.
REQ-006 clk  input  1  sole clock; all logic on the rising edge.
REQ-007 rst_n  input  1  reset; synchronous, active-low.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_addr  input  ADDR  write address.
REQ-010 wr_data  input  WIDTH  write data.
REQ-011 wr_be  input  LANES  per-lane write enable; bit i covers data bits [(i+1)*WIDTH/LANES-1 : i*WIDTH/LANES].
REQ-012 rd_en  input  1  read request.
REQ-013 rd_addr  input  ADDR  read address.
REQ-014 rd_data  output  WIDTH  read data; valid only while rd_valid is high.
REQ-015 rd_valid  output  1  rd_data holds the response to an accepted read.
REQ-016 busy  output  1  initialisation sweep in progress; requests are ignored.

Function
REQ-017 The FSM SHALL have two states. S_INIT writes INIT_VAL to address init_ptr (all lanes) each cycle and increments init_ptr. It moves to S_RUN in the cycle after writing address 2**ADDR-1.
REQ-018 busy SHALL be high exactly while the FSM is in S_INIT; the sweep SHALL take 2**ADDR cycles.
REQ-019 In S_INIT, wr_en and rd_en SHALL be ignored: no memory change, no rd_valid pulse.
REQ-020 In S_RUN, wr_en=1 SHALL update only the lanes of mem[wr_addr] whose wr_be bit is 1, at the clock edge. wr_be=0 with wr_en=1 SHALL change nothing.
REQ-021 In S_RUN, rd_en=1 in cycle N SHALL give rd_valid=1 and rd_data=mem[rd_addr] in cycle N+1 (OUT_REG=0) or cycle N+2 (OUT_REG=1).
REQ-022 Back-to-back reads SHALL be fully pipelined, with one response per cycle. rd_valid SHALL be 0 in any cycle that has no matching request.
REQ-023 Read and write to the same address in the same cycle (write-first) SHALL return the new word: enabled lanes from wr_data, disabled lanes from the old memory contents.
REQ-024 A read one cycle after a write to the same address SHALL return the updated word.
REQ-025 Read and write to different addresses in the same cycle SHALL both complete with no interaction.
REQ-026 When rd_valid is 0, rd_data SHALL hold its last value.
REQ-027 Addresses SHALL wrap naturally within 2**ADDR; there is no out-of-range condition.

Reset
REQ-028 While rst_n=0 at a clock edge: the FSM enters S_INIT, init_ptr=0, busy=1, rd_valid=0 (including all pipeline stages), and rd_data=0.
REQ-029 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0 and drop any in-flight responses.
REQ-030 Memory contents SHALL be defined only by the sweep; the memory array itself is not reset.

Structure
REQ-031 Package sdp_ram_pkg SHALL hold the state typedef (S_INIT, S_RUN) and a lane-merge function (old word, new word, be, LANES) -> merged word.
REQ-032 The lane merge from REQ-031 SHALL be shared by the write path and the REQ-023 bypass.
REQ-033 There SHALL be no sub-module; memory, FSM and read pipeline live in sdp_ram.

Verification
REQ-034 Reset, then hold rst_n=1 with default parameters -> busy=1 for exactly 16 cycles, then 0. Reading addresses 0..15 returns 0x00 each, with rd_valid one cycle after each rd_en.
REQ-035 Default parameters, LANES=1 with WIDTH=8 and WIDTH=32/LANES=4: write 0xAABBCCDD to address 3, then write 0x11223344 with wr_be=4'b0101 -> reading address 3 returns 0xAA22CC44.
REQ-036 Same-cycle write 0x5A and read at address 7 -> rd_data=0x5A next cycle. With OUT_REG=1, the same test -> 0x5A two cycles later and rd_valid=0 in the intermediate cycle.
REQ-037 wr_en and rd_en held high during busy -> no rd_valid pulse. After the sweep, all words still equal INIT_VAL (set to 0x3C for this test).
REQ-038 rst_n pulsed low for 1 cycle at sweep cycle 9, with reads in flight -> rd_valid=0 next cycle and busy stays high for 16 further cycles.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM: FSM state encoding
// and the byte-lane merge used by both the write port and the read bypass.
package sdp_ram_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Widest word / lane count the merge helper handles; callers zero-pad into it.
    localparam int MERGE_W = 256;

    // Take each lane from new_word where its be bit is set, otherwise from old_word.
    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_W-1:0] be,
        input int                 lanes,
        input int                 width
    );
        logic [MERGE_W-1:0] merged;
        int                 lane_w;
        lane_w = width / lanes;
        merged = old_word;
        for (int i = 0; i < MERGE_W; i++) begin
            if (i < width && be[i / lane_w]) begin
                merged[i] = new_word[i];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with per-lane write enables, write-first bypass,
// optional output register and a power-up/reset sweep that fills INIT_VAL.
module sdp_ram
    import sdp_ram_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               ADDR     = 4,
    parameter int               LANES    = 1,
    parameter int               OUT_REG  = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ADDR-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [LANES-1:0] wr_be,
    input  logic             rd_en,
    input  logic [ADDR-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy
);

    localparam int DEPTH = 2 ** ADDR;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_reg, state_next;
    logic [ADDR-1:0]  init_ptr_reg, init_ptr_next;

    logic             run;
    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] rd_word;

    logic [MERGE_W-1:0] old_pad, new_pad, be_pad, merged_pad;
    logic               unused_merge_bits;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_data_reg;

    assign run     = (state_reg == S_RUN);
    assign wr_fire = run && wr_en;
    assign rd_fire = run && rd_en;
    assign busy    = !run;

    // FSM: sweep every address once, then run.
    always_comb begin
        state_next    = state_reg;
        init_ptr_next = init_ptr_reg;
        if (state_reg == S_INIT) begin
            init_ptr_next = init_ptr_reg + ADDR'(1);
            if (&init_ptr_reg) begin
                state_next = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_INIT;
            init_ptr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_ptr_reg <= init_ptr_next;
        end
    end

    // The merged word feeds both the memory write and the same-address read bypass.
    always_comb begin
        old_pad              = '0;
        new_pad              = '0;
        be_pad               = '0;
        old_pad[WIDTH-1:0]   = mem[wr_addr];
        new_pad[WIDTH-1:0]   = wr_data;
        be_pad[LANES-1:0]    = wr_be;
        merged_pad           = lane_merge(old_pad, new_pad, be_pad, LANES, WIDTH);
        wr_word              = merged_pad[WIDTH-1:0];
    end

    assign unused_merge_bits = ^merged_pad;

    assign rd_word = (wr_fire && (wr_addr == rd_addr)) ? wr_word : mem[rd_addr];

    // Memory contents are never reset; only the sweep defines them.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                mem[init_ptr_reg] <= INIT_VAL;
            end else if (wr_fire) begin
                mem[wr_addr] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= rd_fire;
            if (rd_fire) begin
                s1_data_reg <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             s2_valid_reg;
            logic [WIDTH-1:0] s2_data_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s2_valid_reg <= 1'b0;
                    s2_data_reg  <= '0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        s2_data_reg <= s1_data_reg;
                    end
                end
            end

            assign rd_valid = s2_valid_reg;
            assign rd_data  = s2_data_reg;
        end else begin : g_no_out_reg
            assign rd_valid = s1_valid_reg;
            assign rd_data  = s1_data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram.sv
// Bench for sdp_ram: an 8-bit single-lane latency-1 instance and a 32-bit
// four-lane latency-2 instance share stimulus; a scoreboard checks every cycle.
module tb_sdp_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic [7:0]  a_rd_data;
    logic        a_rd_valid, a_busy;
    logic [31:0] b_rd_data;
    logic        b_rd_valid, b_busy;

    always #5 clk = ~clk;

    sdp_ram #(
        .WIDTH(8), .ADDR(4), .LANES(1), .OUT_REG(0), .INIT_VAL(8'h00)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy)
    );

    sdp_ram #(
        .WIDTH(32), .ADDR(4), .LANES(4), .OUT_REG(1), .INIT_VAL(32'h0000003C)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    vec_t        vecs[10];
    int          cyc     = 0;
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] last_a  = 32'h0;
    logic [31:0] last_b  = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reset drops all in-flight responses and clears the held output.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
            last_a = 32'h0;
            last_b = 32'h0;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (q_a.size() > 0 && q_a[0].due == cyc) begin
                chk("a_valid", 32'(a_rd_valid), 32'd1);
                chk("a_data", 32'(a_rd_data), q_a[0].data);
                $display("resp A cycle %0d data %h expected %h", cyc, a_rd_data, q_a[0].data);
                last_a = q_a[0].data;
                void'(q_a.pop_front());
            end else begin
                chk("a_idle_valid", 32'(a_rd_valid), 32'd0);
                chk("a_hold_data", 32'(a_rd_data), last_a);
            end
            if (q_b.size() > 0 && q_b[0].due == cyc) begin
                chk("b_valid", 32'(b_rd_valid), 32'd1);
                chk("b_data", b_rd_data, q_b[0].data);
                $display("resp B cycle %0d data %h expected %h", cyc, b_rd_data, q_b[0].data);
                last_b = q_b[0].data;
                void'(q_b.pop_front());
            end else begin
                chk("b_idle_valid", 32'(b_rd_valid), 32'd0);
                chk("b_hold_data", b_rd_data, last_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = 4'h0;
    endtask

    task automatic push_read(input logic [31:0] ea, input logic [31:0] eb);
        q_a.push_back('{due: cyc + 1, data: ea});
        q_b.push_back('{due: cyc + 2, data: eb});
    endtask

    // Called just after a reset edge: busy for 16 cycles, then low.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_busy_a"}, 32'(a_busy), 32'd1);
            chk({tag, "_busy_b"}, 32'(b_busy), 32'd1);
            step();
        end
        chk({tag, "_done_a"}, 32'(a_busy), 32'd0);
        chk({tag, "_done_b"}, 32'(b_busy), 32'd0);
        $display("sweep %s complete at cycle %0d", tag, cyc);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_addr = 4'd0;
        rd_addr = 4'd0;
        wr_data = 32'h0;
        idle();

        //           we    wa     wd            be    re    ra     exp_a     exp_b
        vecs[0] = '{1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0, 32'h00, 32'h00000000};
        vecs[1] = '{1'b1, 4'd3, 32'h11223344, 4'h5, 1'b0, 4'd0, 32'h00, 32'h00000000};
        vecs[2] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd3, 32'h44, 32'hAA22CC44};
        vecs[3] = '{1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd3, 32'h44, 32'hAA22CC44};
        vecs[4] = '{1'b1, 4'd7, 32'h0000005A, 4'hF, 1'b1, 4'd7, 32'h5A, 32'h0000005A};
        vecs[5] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd7, 32'h5A, 32'h0000005A};
        vecs[6] = '{1'b1, 4'd2, 32'h12345678, 4'hF, 1'b1, 4'd0, 32'h00, 32'h0000003C};
        vecs[7] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd2, 32'h78, 32'h12345678};
        vecs[8] = '{1'b1, 4'd2, 32'h9ABCDEF0, 4'hA, 1'b1, 4'd2, 32'h78, 32'h9A34DE78};
        vecs[9] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd15, 32'h00, 32'h0000003C};

        repeat (3) step();

        // Requests held high through the sweep must be ignored.
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_be   = 4'hF;
        wr_data = 32'hFFFFFFFF;
        wr_addr = 4'd5;
        rd_addr = 4'd5;
        rst_n   = 1'b1;
        check_sweep("init");
        idle();

        for (int a = 0; a < 16; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            push_read(32'h00, 32'h0000003C);
            step();
        end
        idle();
        repeat (3) step();

        for (int i = 0; i < 10; i++) begin
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            wr_be   = vecs[i].be;
            rd_en   = vecs[i].re;
            rd_addr = vecs[i].ra;
            if (vecs[i].re) begin
                push_read(vecs[i].exp_a, vecs[i].exp_b);
            end
            $display("vec %0d we=%b wa=%0d wd=%h be=%h re=%b ra=%0d", i,
                     vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].re, vecs[i].ra);
            step();
        end
        idle();
        repeat (3) step();

        // Reset one cycle after a read: A answers first, B's response must be dropped.
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        push_read(32'h44, 32'hAA22CC44);
        step();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Reset pulse part-way through the sweep, reads requested throughout.
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        for (int i = 0; i < 9; i++) begin
            chk("mid_busy_a", 32'(a_busy), 32'd1);
            chk("mid_busy_b", 32'(b_busy), 32'd1);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        check_sweep("restart");

        rd_en   = 1'b1;
        rd_addr = 4'd3;
        push_read(32'h00, 32'h0000003C);
        step();
        rd_addr = 4'd7;
        push_read(32'h00, 32'h0000003C);
        step();
        idle();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
